fp32_stream_dma: RTL and testbench

FP32_STREAM_DMA -- requirements
Module: fp32_stream_dma

---
 rtl/ae_dma_pkg.sv | 12 +
 rtl/fifo2_64.sv | 54 +++++
 rtl/fp32_stream_dma.sv | 126 ++++++++++++
 tb/tb_fp32_stream_dma.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ae_dma_pkg.sv
// Shared constants for the fp32x2 stream DMA:
// FSM state encoding and read FIFO depth.
package ae_dma_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/fifo2_64.sv
// Two-entry 64-bit FIFO holding read beats
// returned by the buffer until the stream takes them.
module fifo2_64
    import ae_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [63:0] din,
    input  logic        pop,
    output logic [63:0] dout,
    output logic        valid,
    output logic [1:0]  count
);

    logic [63:0] ent0_q;
    logic [63:0] ent1_q;
    logic        wp_q;
    logic        rp_q;
    logic [1:0]  cnt_q;
    logic        push_ok;
    logic        pop_ok;

    assign pop_ok  = pop && (cnt_q != 2'd0);
    assign push_ok = push && ((cnt_q != 2'(FIFO_DEPTH)) || pop_ok);

    assign dout  = rp_q ? ent1_q : ent0_q;
    assign valid = (cnt_q != 2'd0);
    assign count = cnt_q;

    // Storage, pointers and occupancy; push+pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                if (wp_q) ent1_q <= din;
                else      ent0_q <= din;
                wp_q <= ~wp_q;
            end
            if (pop_ok) rp_q <= ~rp_q;
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fp32_stream_dma.sv
// Moves fp32x2 beats between a valid/ready stream
// and the converter buffer port, one beat per cycle.
module fp32_stream_dma
    import ae_dma_pkg::*;
#(
    parameter int ADDR_MW = 15,
    parameter int LEN_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               dir,
    input  logic [ADDR_MW-1:0] base_addr,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [63:0]        s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [63:0]        m_data,
    output logic [ADDR_MW-1:0] bc_addr_m,
    output logic [63:0]        bc_din_fp32x2,
    output logic [7:0]         bc_we_m,
    input  logic [63:0]        bc_dout_fp32x2
);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [ADDR_MW-1:0] addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_q;
    logic [LEN_W-1:0]   pop_q;
    logic               rd_pend_q;
    logic [1:0]         fifo_cnt;
    logic [2:0]         occ_after;
    logic               wr_fire;
    logic               rd_issue;
    logic               rd_pop;
    logic               last_wr;
    logic               last_rd;
    logic               unused_lsb;

    assign unused_lsb = ^base_addr[2:0];

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign s_ready = (state_q == ST_WRITE);

    assign wr_fire = s_ready && s_valid;
    assign rd_pop  = m_valid && m_ready;

    // Slots still claimed after this cycle's pop; a
    // same-cycle pop frees room so reads can stream.
    assign occ_after = {1'b0, fifo_cnt} + {2'b00, rd_pend_q}
                     - {2'b00, rd_pop};

    assign rd_issue = (state_q == ST_READ)
                   && (beat_q != len_q)
                   && (occ_after < 3'(FIFO_DEPTH));

    assign last_wr = wr_fire && (beat_q == len_q - LEN_W'(1));
    assign last_rd = rd_pop && (pop_q == len_q - LEN_W'(1));

    assign bc_we_m       = wr_fire ? 8'hFF : 8'h00;
    assign bc_addr_m     = addr_q;
    assign bc_din_fp32x2 = wr_fire ? s_data : 64'd0;

    // Next-state decode for the command sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) state_d = ST_DONE;
                    else if (dir)  state_d = ST_READ;
                    else           state_d = ST_WRITE;
                end
            end
            ST_WRITE: if (last_wr) state_d = ST_DONE;
            ST_READ:  if (last_rd) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Command latch, address walk and beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            pop_q     <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_issue;
            if (state_q == ST_IDLE && start) begin
                addr_q <= {base_addr[ADDR_MW-1:3], 3'b000};
                len_q  <= len;
                beat_q <= '0;
                pop_q  <= '0;
            end else begin
                if (wr_fire || rd_issue) begin
                    addr_q <= addr_q + ADDR_MW'(8);
                    beat_q <= beat_q + LEN_W'(1);
                end
                if (rd_pop) pop_q <= pop_q + LEN_W'(1);
            end
        end
    end

    fifo2_64 u_rd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pend_q),
        .din   (bc_dout_fp32x2),
        .pop   (rd_pop),
        .dout  (m_data),
        .valid (m_valid),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_fp32_stream_dma.sv
// Bench for fp32_stream_dma: buffer model,
// write/read scoreboards, command table plus corner sequences.
module tb_fp32_stream_dma;

    localparam int AW = 15;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          dir;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          s_valid;
    logic          s_ready;
    logic [63:0]   s_data;
    logic          m_valid;
    logic          m_ready;
    logic [63:0]   m_data;
    logic [AW-1:0] bc_addr_m;
    logic [63:0]   bc_din_fp32x2;
    logic [7:0]    bc_we_m;
    logic [63:0]   bc_dout_fp32x2;

    always #5 clk = ~clk;

    fp32_stream_dma #(
        .ADDR_MW (AW),
        .LEN_W   (LW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .dir            (dir),
        .base_addr      (base_addr),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .bc_addr_m      (bc_addr_m),
        .bc_din_fp32x2  (bc_din_fp32x2),
        .bc_we_m        (bc_we_m),
        .bc_dout_fp32x2 (bc_dout_fp32x2)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [63:0]   d;
    } wbeat_t;

    typedef struct {
        logic          d;
        logic [AW-1:0] base;
        logic [LW-1:0] n;
        int            rmode;
        int            exp_cyc;
        int            exp_last;
        string         tag;
    } vec_t;

    logic [63:0]   mem [0:4095];
    logic          mem_init = 1'b0;
    wbeat_t        wexp[$];
    logic [63:0]   rexp[$];
    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    logic [AW-1:0] last_waddr = '0;
    logic          hold_q = 1'b0;
    logic [63:0]   hold_d = '0;

    function automatic logic [63:0] pat(int i);
        return {32'h3f80_0000 + 32'(i), 32'hc000_0000 ^ 32'(i)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Buffer model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] = pat(i);
            mem_init = 1'b1;
        end else if (bc_we_m == 8'hFF) begin
            mem[bc_addr_m[AW-1:3]] = bc_din_fp32x2;
        end
        bc_dout_fp32x2 <= mem[bc_addr_m[AW-1:3]];
    end

    // Output monitor: write beats, read beats, hold stability.
    always @(negedge clk) begin
        wbeat_t w;
        logic [63:0] e;
        if (!rst_n) begin
            hold_q = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (bc_we_m != 8'h00) begin
                chk("wr_mask", 64'(bc_we_m), 64'hFF);
                if (wexp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected actual=%h required=none",
                             bc_addr_m);
                end else begin
                    w = wexp.pop_front();
                    chk("wr_addr", 64'(bc_addr_m), 64'(w.a));
                    chk("wr_data", bc_din_fp32x2, w.d);
                    last_waddr = bc_addr_m;
                end
            end
            if (hold_q) begin
                chk("m_hold_valid", 64'(m_valid), 64'd1);
                chk("m_hold_data", m_data, hold_d);
            end
            if (m_valid && m_ready) begin
                if (rexp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected actual=%h required=none",
                             m_data);
                end else begin
                    e = rexp.pop_front();
                    chk("rd_data", m_data, e);
                end
            end
            hold_q = m_valid && !m_ready;
            hold_d = m_data;
        end
    end

    task automatic chk_reset(string t);
        chk({t, "_busy"}, 64'(busy), 64'd0);
        chk({t, "_done"}, 64'(done), 64'd0);
        chk({t, "_sready"}, 64'(s_ready), 64'd0);
        chk({t, "_mvalid"}, 64'(m_valid), 64'd0);
        chk({t, "_we"}, 64'(bc_we_m), 64'd0);
        chk({t, "_addr"}, 64'(bc_addr_m), 64'd0);
        chk({t, "_din"}, bc_din_fp32x2, 64'd0);
    endtask

    task automatic run_cmd(input vec_t v);
        logic [AW-1:0] ab;
        logic [AW-1:0] a;
        logic [63:0]   wd[$];
        logic [63:0]   x;
        logic          fire;
        int            cyc;
        int            idx;
        int            first_mv;
        int            dc0;
        ab = {v.base[AW-1:3], 3'b000};
        for (int i = 0; i < int'(v.n); i++) begin
            a = ab + AW'(i * 8);
            if (!v.d) begin
                x = {$urandom, $urandom};
                wd.push_back(x);
                wexp.push_back('{a, x});
            end else begin
                rexp.push_back(mem[a[AW-1:3]]);
            end
        end
        dc0 = done_cnt;
        dir = v.d;
        base_addr = v.base;
        len = v.n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        len = LW'($urandom);
        base_addr = AW'($urandom);
        cyc = 0;
        idx = 0;
        first_mv = -1;
        while (1) begin
            if (!v.d) begin
                s_valid = (idx < int'(v.n))
                       && (v.rmode == 0 || $urandom_range(0, 1) == 1);
                s_data = s_valid ? wd[idx] : {$urandom, $urandom};
            end else if (v.rmode == 1) begin
                m_ready = !(cyc >= 3 && cyc < 8);
            end else if (v.rmode == 2) begin
                m_ready = ($urandom_range(0, 1) == 1);
            end else begin
                m_ready = 1'b1;
            end
            @(negedge clk);
            if (done) break;
            if (m_valid && first_mv < 0) first_mv = cyc;
            fire = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (fire) idx++;
            cyc++;
            if (cyc > 400) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout actual=%0d required=done", v.tag, cyc);
                break;
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        if (v.exp_cyc >= 0)
            chk({v.tag, "_cyc"}, 64'(cyc), 64'(v.exp_cyc));
        if (v.d && v.rmode == 0 && v.n != 0)
            chk({v.tag, "_first_mv"}, 64'(first_mv), 64'd2);
        if (v.exp_last >= 0)
            chk({v.tag, "_last_addr"}, 64'(last_waddr), 64'(v.exp_last));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({v.tag, "_idle"}, 64'(busy), 64'd0);
        chk({v.tag, "_ndone"}, 64'(done_cnt - dc0), 64'd1);
        chk({v.tag, "_wq"}, 64'(wexp.size()), 64'd0);
        chk({v.tag, "_rq"}, 64'(rexp.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];

    initial begin
        int dc0;
        tbl[0] = '{1'b0, 15'h0010, 12'd3, 0, 3, 32'h0020, "w_basic"};
        tbl[1] = '{1'b1, 15'h0000, 12'd4, 0, 6, -1, "r_basic"};
        tbl[2] = '{1'b1, 15'h0010, 12'd3, 0, 5, -1, "r_back"};
        tbl[3] = '{1'b0, 15'h0000, 12'd0, 0, 0, -1, "w_len0"};
        tbl[4] = '{1'b1, 15'h0040, 12'd0, 0, 0, -1, "r_len0"};
        tbl[5] = '{1'b0, 15'h7FF8, 12'd2, 0, 2, 32'h0000, "w_wrap"};
        tbl[6] = '{1'b1, 15'h7FF8, 12'd2, 0, 4, -1, "r_wrap"};
        tbl[7] = '{1'b1, 15'h0100, 12'd8, 1, -1, -1, "r_stall"};
        tbl[8] = '{1'b0, 15'h0203, 12'd6, 2, -1, 32'h0228, "w_gaps"};
        tbl[9] = '{1'b1, 15'h0200, 12'd6, 2, -1, -1, "r_rand"};

        rst_n = 1'b0;
        start = 1'b0;
        dir = 1'b0;
        base_addr = '0;
        len = '0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

        // start pulsed while a write is waiting for data
        wexp.push_back('{15'h0400, 64'h3f80_0000_4000_0000});
        wexp.push_back('{15'h0408, 64'hbf80_0000_c040_0000});
        dc0 = done_cnt;
        dir = 1'b0;
        base_addr = 15'h0400;
        len = 12'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        dir = 1'b1;
        len = 12'd5;
        base_addr = 15'h0600;
        @(negedge clk);
        chk("busy_start_sready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 64'h3f80_0000_4000_0000;
        @(posedge clk);
        #1;
        s_data = 64'hbf80_0000_c040_0000;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("busy_start_done", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_start_idle", 64'(busy), 64'd0);
        chk("busy_start_ndone", 64'(done_cnt - dc0), 64'd1);
        chk("busy_start_wq", 64'(wexp.size()), 64'd0);
        @(posedge clk);
        #1;

        // reset in the middle of a stalled read
        dir = 1'b1;
        base_addr = 15'h0000;
        len = 12'd8;
        m_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_mvalid", 64'(m_valid), 64'd1);
        dc0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_nodone", 64'(done_cnt - dc0), 64'd0);
        run_cmd('{1'b1, 15'h0400, 12'd2, 0, 4, -1, "r_after_rst"});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
